mips_boot_ctrl: RTL

Boot-and-run controller for the MIPS core. It streams a program image into instruction memory over a valid/ready port and holds the core in reset for a parametrised settle period. It then releases the core and supervises the run until the PC reaches a halt address or a cycle budget expires. It sits beside `mips` at the system top and drives the core's `rst` and the IM write port.

---
 rtl/mips_pkg.sv | 9 +
 rtl/sat_counter.sv | 19 +
 rtl/mips_boot_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared state type and default sizing for the MIPS system top
package mips_pkg;
  typedef enum logic [1:0] {LOAD, HOLD, RUN, HALT} state_t;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RST_HOLD = 4;
  localparam int DEF_CNT_W = 32;
  // The core PC is a byte address; IM is word-addressed, so pc = {pcout, 2'b00}.
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up or down counter with clear-to-init, enable and saturation
module sat_counter #(
  parameter int W = 8,
  parameter bit UP = 1'b1,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] START = W'(INIT);
  localparam logic [W-1:0] LIMIT = UP ? '1 : '0;
  always_ff @(posedge clk) begin
    if (rst || clr) q <= START;
    else if (en && q != LIMIT) q <= UP ? q + 1'b1 : q - 1'b1;
  end
endmodule

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl: loads an image into IM, holds the core in reset, then supervises the run
module mips_boot_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RST_HOLD = DEF_RST_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       halt_pc,
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  cycles_run
);
  localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
  state_t state, nxt;
  logic hs, at_end, hit, expire, restart;
  logic [HW-1:0] hold_q;
  assign hs = s_valid && s_ready;
  assign at_end = hs && (s_last || words_loaded[ADDR_W-1:0] == '1);
  assign hit = cpu_pc == halt_pc;
  assign expire = cycle_limit != '0 && cycles_run + CNT_W'(1) == cycle_limit;
  assign restart = state == HALT && start;
  always_comb begin
    nxt = state == LOAD ? (at_end ? HOLD : LOAD) :
          state == HOLD ? (hold_q == '0 ? RUN : HOLD) :
          state == RUN  ? (hit || expire ? HALT : RUN) :
          (start ? LOAD : HALT);
  end
  sat_counter #(.W(CNT_W), .UP(1'b1), .INIT(0)) u_cycles (
    .clk(clk), .rst(rst), .clr(restart), .en(state == RUN), .q(cycles_run)
  );
  // Parked at RST_HOLD-1 outside HOLD so that HOLD lasts exactly RST_HOLD cycles.
  sat_counter #(.W(HW), .UP(1'b0), .INIT(RST_HOLD - 1)) u_hold (
    .clk(clk), .rst(rst), .clr(state != HOLD), .en(state == HOLD), .q(hold_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      s_ready <= 1'b0;
      im_we <= 1'b0;
      im_addr <= '0;
      im_wdata <= '0;
      cpu_rst <= 1'b1;
      done <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= nxt;
      s_ready <= nxt == LOAD;
      cpu_rst <= nxt != RUN;
      im_we <= hs;
      if (hs) begin
        im_addr <= words_loaded[ADDR_W-1:0];
        im_wdata <= s_data;
      end
      if (restart) begin
        done <= 1'b0;
        timeout <= 1'b0;
        overflow <= 1'b0;
        words_loaded <= '0;
      end else begin
        words_loaded <= words_loaded + (ADDR_W+1)'(hs);
        done <= done | (state == RUN && hit);
        timeout <= timeout | (state == RUN && !hit && expire);
        overflow <= overflow | (at_end && !s_last);
      end
    end
  end
endmodule
